// File: rtl/mlp_inference_ctrl.sv
// rtl/mlp_inference_ctrl.sv - feature loader, settle timer and label rounding/clamp around a combinational MLP
`timescale 1ns/1ps

module mlp_inference_ctrl #(
    parameter int WIDTH_A       = 4,
    parameter int NUM_A         = 11,
    parameter int OUTWIDTH      = 21,
    parameter int FRAC          = 14,
    parameter int MAX_CLASS     = 9,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         in_data,
    output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
    input  logic [OUTWIDTH-1:0]        mlp_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_class,
    output logic [OUTWIDTH-1:0]        out_raw,
    output logic                       out_sat,
    output logic                       busy
);

    localparam int BCW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW  = OUTWIDTH - FRAC;

    localparam logic [BCW-1:0]  LAST_BEAT = BCW'(NUM_A - 1);
    localparam logic [SCW-1:0]  SETTLE_LD = SCW'(SETTLE_CYCLES);
    localparam logic [FRAC-1:0] HALF      = FRAC'(1) << (FRAC - 1);
    localparam logic [IW:0]     MAXC      = (IW + 1)'(MAX_CLASS);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [BCW-1:0] beat_cnt;
    logic [SCW-1:0] settle_cnt;

    logic in_fire;
    logic last_beat;
    logic settle_done;
    logic out_fire;

    logic [IW-1:0]   int_part;
    logic [FRAC-1:0] frac_part;
    logic [IW:0]     rounded;
    logic            clamp;
    logic [3:0]      label;

    assign in_fire     = in_valid && in_ready;
    assign last_beat   = in_fire && (beat_cnt == LAST_BEAT);
    // The capture edge is the one on which the settle counter goes 1 -> 0.
    assign settle_done = (state == S_SETTLE) && (settle_cnt == SCW'(1));
    assign out_fire    = out_valid && out_ready;

    // Round half-down on the fraction, widened by one bit so the integer part never wraps.
    always_comb begin
        int_part  = mlp_out[OUTWIDTH-1:FRAC];
        frac_part = mlp_out[FRAC-1:0];
        rounded   = {1'b0, int_part} + {{IW{1'b0}}, (frac_part > HALF)};
        clamp     = (rounded > MAXC);
        label     = clamp ? 4'(MAX_CLASS) : 4'(rounded);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: load until the last beat, settle for a fixed count, hold until consumed.
    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:   if (last_beat)   state_nx = S_SETTLE;
            S_SETTLE: if (settle_done) state_nx = S_HOLD;
            S_HOLD:   if (out_fire)    state_nx = S_LOAD;
            default:                   state_nx = S_LOAD;
        endcase
    end

    // Handshake and status outputs decoded from state alone (no bypass from out_ready to in_ready).
    always_comb begin
        in_ready  = (state == S_LOAD);
        out_valid = (state == S_HOLD);
        busy      = (state != S_LOAD);
    end

    // Beat counter and settle timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            if (in_fire) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + BCW'(1);
            end
            if (last_beat) begin
                settle_cnt <= SETTLE_LD;
            end else if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt - SCW'(1);
            end
        end
    end

    // Feature registers: written only by accepted beats, kept between samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mlp_inp <= '0;
        end else if (in_fire) begin
            for (int i = 0; i < NUM_A; i++) begin
                if (beat_cnt == BCW'(i)) begin
                    mlp_inp[i*WIDTH_A +: WIDTH_A] <= in_data;
                end
            end
        end
    end

    // Result capture: mlp_out is sampled only on the settle-done edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_class <= '0;
            out_raw   <= '0;
            out_sat   <= 1'b0;
        end else if (settle_done) begin
            out_class <= label;
            out_raw   <= mlp_out;
            out_sat   <= clamp;
        end
    end

endmodule
